// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Decode-stage register-read controller. Decodes rs1/rs2 read enables and
//   the rd write enable from a 32-bit RISC-V instruction, tracks pending
//   writebacks per register in a small up/down counter, stalls instructions
//   whose sources are still pending, and presents accepted operand addresses
//   through a one-entry registered issue stage.
//
//   Optional feature macro: REG_SB_BYPASS_EN
//     defined   - a source whose count is 1 and whose writeback arrives in the
//                 same cycle is not a hazard (issues in the writeback cycle)
//     undefined - a pending source stalls until its count has reached 0
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   instr/instr_valid  instruction from fetch; instr_ready = accepted this cycle
//   issue_valid        issue stage holds an instruction; issue_ready pops it
//   rs1_addr/rs1_rden  registered rs1 address (0 when disabled) and enable
//   rs2_addr/rs2_rden  registered rs2 address (0 when disabled) and enable
//   rd_addr/rd_wren    registered rd address (0 when disabled) and enable
//   ill_reg            registered; an enabled field addresses a reg >= NREG
//   wb_valid/wb_addr   writeback retiring one pending write
//   flush              kill the issue stage and clear the scoreboard
//   hazard             combinational stall indication for the current instr
//   sb_err             sticky; writeback to a register whose count is 0

module reg_scoreboard #(
    parameter int unsigned NREG   = 32,
    parameter int unsigned CNT_W  = 2,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [ADDR_W-1:0] rs1_addr,
    output logic [ADDR_W-1:0] rs2_addr,
    output logic              rs1_rden,
    output logic              rs2_rden,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_wren,
    output logic              ill_reg,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic              flush,
    output logic              hazard,
    output logic              sb_err
);

    localparam int unsigned      NSLOT   = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011,
        OP_MEM    = 7'b0001111
    } opcode_t;

    // Counters for every encodable address; slots 0 and >= NREG stay at 0.
    logic [CNT_W-1:0]  r_cnt [NSLOT];
    logic              r_issue_valid;
    logic [ADDR_W-1:0] r_rs1_addr, r_rs2_addr, r_rd_addr;
    logic              r_rs1_rden, r_rs2_rden, r_rd_wren, r_ill_reg, r_sb_err;

    opcode_t           w_opcode;
    logic [ADDR_W-1:0] w_rs1, w_rs2, w_rd;
    logic              w_rs1_rden, w_rs2_rden, w_rd_wren;
    logic              w_rs1_ok, w_rs2_ok, w_rd_ok, w_wb_ok;
    logic [CNT_W-1:0]  w_cnt_rs1, w_cnt_rs2, w_cnt_rd, w_cnt_wb;
    logic              w_rs1_byp, w_rs2_byp;
    logic              w_rs1_busy, w_rs2_busy, w_rd_full, w_stall;
    logic              w_accept, w_inc, w_wb_live, w_dec, w_wb_err, w_ill;
    logic              w_unused_bits;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < NREG;
    endfunction

    assign w_opcode = opcode_t'(instr[6:0]);
    assign w_rd     = instr[11:7];
    assign w_rs1    = instr[19:15];
    assign w_rs2    = instr[24:20];
    // funct3/funct7 are not needed for register decode.
    assign w_unused_bits = ^{instr[31:25], instr[14:12]};

    always_comb begin
        w_rs1_rden = 1'b0;
        w_rs2_rden = 1'b0;
        w_rd_wren  = 1'b0;
        case (w_opcode)
            OP_LUI, OP_AUIPC, OP_JAL: w_rd_wren = 1'b1;
            OP_JALR, OP_LOAD, OP_IMM: begin
                w_rs1_rden = 1'b1;
                w_rd_wren  = 1'b1;
            end
            OP_BRANCH, OP_STORE: begin
                w_rs1_rden = 1'b1;
                w_rs2_rden = 1'b1;
            end
            OP_REG: begin
                w_rs1_rden = 1'b1;
                w_rs2_rden = 1'b1;
                w_rd_wren  = 1'b1;
            end
            OP_MEM:  w_rs1_rden = 1'b1;
            default: ;
        endcase
        if (w_rd == '0) w_rd_wren = 1'b0;
    end

    assign w_rs1_ok = in_range(w_rs1);
    assign w_rs2_ok = in_range(w_rs2);
    assign w_rd_ok  = in_range(w_rd);
    assign w_wb_ok  = in_range(wb_addr);

    assign w_cnt_rs1 = r_cnt[w_rs1];
    assign w_cnt_rs2 = r_cnt[w_rs2];
    assign w_cnt_rd  = r_cnt[w_rd];
    assign w_cnt_wb  = r_cnt[wb_addr];

`ifdef REG_SB_BYPASS_EN
    assign w_rs1_byp = (w_cnt_rs1 == CNT_W'(1)) && wb_valid && (wb_addr == w_rs1);
    assign w_rs2_byp = (w_cnt_rs2 == CNT_W'(1)) && wb_valid && (wb_addr == w_rs2);
`else
    assign w_rs1_byp = 1'b0;
    assign w_rs2_byp = 1'b0;
`endif

    assign w_rs1_busy = w_rs1_rden && (w_rs1 != '0) && w_rs1_ok && (w_cnt_rs1 != '0) && !w_rs1_byp;
    assign w_rs2_busy = w_rs2_rden && (w_rs2 != '0) && w_rs2_ok && (w_cnt_rs2 != '0) && !w_rs2_byp;
    assign w_rd_full  = w_rd_wren && w_rd_ok && (w_cnt_rd == CNT_MAX);
    assign w_stall    = w_rs1_busy || w_rs2_busy || w_rd_full;

    assign hazard      = instr_valid && w_stall;
    assign instr_ready = !hazard && !flush && (!r_issue_valid || issue_ready);
    assign w_accept    = instr_valid && instr_ready;

    assign w_inc     = w_accept && w_rd_wren && w_rd_ok;
    assign w_wb_live = wb_valid && (wb_addr != '0) && w_wb_ok;
    assign w_dec     = w_wb_live && (w_cnt_wb != '0);
    assign w_wb_err  = w_wb_live && (w_cnt_wb == '0);

    assign w_ill = (w_rs1_rden && !w_rs1_ok) || (w_rs2_rden && !w_rs2_ok) ||
                   (w_rd_wren && !w_rd_ok);

    // Simultaneous increment and decrement of one slot cancel out.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NSLOT; i++) begin
            if (rst || flush || (i == 0) || (i >= NREG)) begin
                r_cnt[i] <= '0;
            end else begin
                case ({w_inc && (w_rd == ADDR_W'(i)), w_dec && (wb_addr == ADDR_W'(i))})
                    2'b10:   r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    2'b01:   r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_valid <= 1'b0;
            r_rs1_addr    <= '0;
            r_rs2_addr    <= '0;
            r_rd_addr     <= '0;
            r_rs1_rden    <= 1'b0;
            r_rs2_rden    <= 1'b0;
            r_rd_wren     <= 1'b0;
            r_ill_reg     <= 1'b0;
        end else if (flush) begin
            r_issue_valid <= 1'b0;
        end else if (w_accept) begin
            r_issue_valid <= 1'b1;
            r_rs1_addr    <= w_rs1_rden ? w_rs1 : '0;
            r_rs2_addr    <= w_rs2_rden ? w_rs2 : '0;
            r_rd_addr     <= w_rd_wren  ? w_rd  : '0;
            r_rs1_rden    <= w_rs1_rden;
            r_rs2_rden    <= w_rs2_rden;
            r_rd_wren     <= w_rd_wren;
            r_ill_reg     <= w_ill;
        end else if (issue_ready) begin
            r_issue_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                       r_sb_err <= 1'b0;
        else if (!flush && w_wb_err)   r_sb_err <= 1'b1;
    end

    assign issue_valid = r_issue_valid;
    assign rs1_addr    = r_rs1_addr;
    assign rs2_addr    = r_rs2_addr;
    assign rd_addr     = r_rd_addr;
    assign rs1_rden    = r_rs1_rden;
    assign rs2_rden    = r_rs2_rden;
    assign rd_wren     = r_rd_wren;
    assign ill_reg     = r_ill_reg;
    assign sb_err      = r_sb_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Testbench for reg_scoreboard: decode table, directed scoreboard sequences,
// an NREG=16 instance for out-of-range handling, and randomized traffic
// against a counter-array reference model.

module tb_reg_scoreboard;

    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111, JAL = 7'b1101111,
                           JALR = 7'b1100111, BR = 7'b1100011, LD = 7'b0000011,
                           ST = 7'b0100011, OPI = 7'b0010011, OP = 7'b0110011,
                           MEM = 7'b0001111, SYS = 7'b1110011, BAD = 7'b0000000;
    localparam int unsigned MAXC = 3;
`ifdef REG_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0, instr_valid = 1'b0, issue_ready = 1'b1;
    logic        wb_valid = 1'b0, flush = 1'b0;
    logic [31:0] instr = '0;
    logic [4:0]  wb_addr = '0;

    logic       instr_ready, issue_valid, rs1_rden, rs2_rden, rd_wren, ill_reg, hazard, sb_err;
    logic [4:0] rs1_addr, rs2_addr, rd_addr;
    logic       e_instr_ready, e_issue_valid, e_rs1_rden, e_rs2_rden, e_rd_wren;
    logic       e_ill_reg, e_hazard, e_sb_err;
    logic [4:0] e_rs1_addr, e_rs2_addr, e_rd_addr;

    reg_scoreboard #(.NREG(32), .CNT_W(2), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_rden(rs1_rden), .rs2_rden(rs2_rden),
        .rd_addr(rd_addr), .rd_wren(rd_wren), .ill_reg(ill_reg), .wb_valid(wb_valid),
        .wb_addr(wb_addr), .flush(flush), .hazard(hazard), .sb_err(sb_err));

    reg_scoreboard #(.NREG(16), .CNT_W(2), .ADDR_W(5)) dut16 (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(e_instr_ready), .issue_valid(e_issue_valid), .issue_ready(issue_ready),
        .rs1_addr(e_rs1_addr), .rs2_addr(e_rs2_addr), .rs1_rden(e_rs1_rden),
        .rs2_rden(e_rs2_rden), .rd_addr(e_rd_addr), .rd_wren(e_rd_wren), .ill_reg(e_ill_reg),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush), .hazard(e_hazard),
        .sb_err(e_sb_err));

    int n_total = 0, n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        bit r1, r2, w;
        logic [4:0] a1, a2, ad;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t d;
        logic [6:0] op;
        op   = ins[6:0];
        d.r1 = op inside {JALR, BR, LD, ST, OPI, OP, MEM};
        d.r2 = op inside {BR, ST, OP};
        d.w  = (op inside {LUI, AUIPC, JAL, JALR, LD, OPI, OP}) && (ins[11:7] != 5'd0);
        d.a1 = d.r1 ? ins[19:15] : 5'd0;
        d.a2 = d.r2 ? ins[24:20] : 5'd0;
        d.ad = d.w  ? ins[11:7]  : 5'd0;
        return d;
    endfunction

    function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, op};
    endfunction

    // Reference model state (NREG=32 instance)
    int unsigned m_cnt [32];
    bit   m_err, m_iv;
    dec_t m_q;

    function automatic bit pend(input bit en, input logic [4:0] a);
        if (!en || a == 5'd0 || m_cnt[a] == 0) return 1'b0;
        if (BYP && m_cnt[a] == 1 && wb_valid && wb_addr == a) return 1'b0;
        return 1'b1;
    endfunction

    // One clock: check combinational outputs, advance model, check registers.
    task automatic step(input string tag);
        dec_t d;
        bit hz, rdy, acc;
        int unsigned old;
        #1;
        d   = decode(instr);
        hz  = instr_valid && (pend(d.r1, d.a1) || pend(d.r2, d.a2) ||
                              (d.w && m_cnt[d.ad] == MAXC));
        rdy = !hz && !flush && (!m_iv || issue_ready);
        acc = instr_valid && rdy;
        chk({tag, " hazard"}, hazard, hz);
        chk({tag, " instr_ready"}, instr_ready, rdy);
        @(posedge clk);
        if (rst) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_iv = 0; m_err = 0; m_q = '{0, 0, 0, 5'd0, 5'd0, 5'd0};
        end else if (flush) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_iv = 0;
        end else begin
            old = m_cnt[wb_addr];
            if (acc) begin
                m_q = d; m_iv = 1;
                if (d.w) m_cnt[d.ad]++;
            end else if (issue_ready) m_iv = 0;
            if (wb_valid && wb_addr != 5'd0) begin
                if (old == 0) m_err = 1;
                else m_cnt[wb_addr]--;
            end
        end
        #1;
        chk({tag, " issue_valid"}, issue_valid, m_iv);
        chk({tag, " rs1_addr"}, rs1_addr, m_q.a1);
        chk({tag, " rs2_addr"}, rs2_addr, m_q.a2);
        chk({tag, " rd_addr"}, rd_addr, m_q.ad);
        chk({tag, " rs1_rden"}, rs1_rden, m_q.r1);
        chk({tag, " rs2_rden"}, rs2_rden, m_q.r2);
        chk({tag, " rd_wren"}, rd_wren, m_q.w);
        chk({tag, " ill_reg"}, ill_reg, 1'b0);
        chk({tag, " sb_err"}, sb_err, m_err);
    endtask

    typedef struct {
        logic [31:0] ins;
        bit r1, r2, w;
        logic [4:0] a1, a2, ad;
    } vec_t;
    vec_t tbl [13];

    logic [6:0] ops [12] = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OP, MEM, SYS, BAD};

    initial begin
        m_q = '{0, 0, 0, 5'd0, 5'd0, 5'd0};
        tbl[0]  = '{enc(LUI, 5, 1, 2),     0, 0, 1, 5'd0,  5'd0,  5'd5};
        tbl[1]  = '{enc(AUIPC, 6, 3, 4),   0, 0, 1, 5'd0,  5'd0,  5'd6};
        tbl[2]  = '{enc(JAL, 1, 7, 8),     0, 0, 1, 5'd0,  5'd0,  5'd1};
        tbl[3]  = '{enc(JALR, 2, 3, 9),    1, 0, 1, 5'd3,  5'd0,  5'd2};
        tbl[4]  = '{enc(BR, 9, 4, 5),      1, 1, 0, 5'd4,  5'd5,  5'd0};
        tbl[5]  = '{enc(LD, 7, 8, 3),      1, 0, 1, 5'd8,  5'd0,  5'd7};
        tbl[6]  = '{enc(ST, 11, 9, 10),    1, 1, 0, 5'd9,  5'd10, 5'd0};
        tbl[7]  = '{enc(OPI, 12, 13, 14),  1, 0, 1, 5'd13, 5'd0,  5'd12};
        tbl[8]  = '{enc(OP, 15, 16, 17),   1, 1, 1, 5'd16, 5'd17, 5'd15};
        tbl[9]  = '{enc(MEM, 19, 18, 20),  1, 0, 0, 5'd18, 5'd0,  5'd0};
        tbl[10] = '{enc(OP, 0, 1, 2),      1, 1, 0, 5'd1,  5'd2,  5'd0};
        tbl[11] = '{enc(SYS, 3, 4, 5),     0, 0, 0, 5'd0,  5'd0,  5'd0};
        tbl[12] = '{enc(BAD, 21, 22, 23),  0, 0, 0, 5'd0,  5'd0,  5'd0};

        #2;
        // Reset held two cycles
        rst = 1; issue_ready = 1;
        step("rst"); step("rst");
        rst = 0;
        #1 chk("reset instr_ready", instr_ready, 1'b1);
        chk("reset issue_valid", issue_valid, 1'b0);
        chk("reset sb_err", sb_err, 1'b0);

        // Decode table: accept one instruction, check fields, flush
        for (int i = 0; i < 13; i++) begin
            instr = tbl[i].ins; instr_valid = 1;
            step("tbl");
            chk("tbl issue_valid", issue_valid, 1'b1);
            chk("tbl rs1_rden", rs1_rden, tbl[i].r1);
            chk("tbl rs2_rden", rs2_rden, tbl[i].r2);
            chk("tbl rd_wren", rd_wren, tbl[i].w);
            chk("tbl rs1_addr", rs1_addr, tbl[i].a1);
            chk("tbl rs2_addr", rs2_addr, tbl[i].a2);
            chk("tbl rd_addr", rd_addr, tbl[i].ad);
            instr_valid = 0; flush = 1;
            step("tbl flush");
            flush = 0;
        end

        // RAW stall: ADDI x5 then ADD x6,x5,x1
        instr = enc(OPI, 5, 0, 0); instr_valid = 1;
        step("addi");
        instr = enc(OP, 6, 5, 1);
        #1 chk("add stall", hazard, 1'b1);
        step("add stall"); step("add stall");
        wb_valid = 1; wb_addr = 5;
        #1 chk("add wb cycle hazard", hazard, BYP ? 1'b0 : 1'b1);
        step("add wb");
        wb_valid = 0;
`ifndef REG_SB_BYPASS_EN
        chk("add not yet issued", issue_valid, 1'b0);
        step("add go");
`endif
        chk("add issued valid", issue_valid, 1'b1);
        chk("add issued rd", rd_addr, 5'd6);
        instr_valid = 0; wb_valid = 1; wb_addr = 6;
        step("wb x6");
        wb_valid = 0;

        // Counter saturation: 3 LOADs to x7, 4th stalls until one wb
        instr = enc(LD, 7, 0, 0); instr_valid = 1;
        step("ld1"); step("ld2"); step("ld3");
        #1 chk("ld4 stall", hazard, 1'b1);
        step("ld4 stall"); step("ld4 stall");
        wb_valid = 1; wb_addr = 7;
        #1 chk("ld4 wb cycle hazard", hazard, 1'b1);
        step("ld4 wb");
        wb_valid = 0;
        chk("ld4 not issued", issue_valid, 1'b0);
        #1 chk("ld4 released", hazard, 1'b0);
        step("ld4 go");
        chk("ld4 issued", issue_valid, 1'b1);
        instr_valid = 0; flush = 1;
        step("flush"); flush = 0;

        // Backpressure: issue fields hold while issue_ready=0
        issue_ready = 0; instr = enc(OP, 10, 1, 2); instr_valid = 1;
        step("bp first");
        instr = enc(OP, 11, 3, 4);
        for (int k = 0; k < 3; k++) begin
            #1 chk("bp instr_ready", instr_ready, 1'b0);
            step("bp hold");
            chk("bp rd held", rd_addr, 5'd10);
            chk("bp rs2 held", rs2_addr, 5'd2);
        end
        issue_ready = 1;
        #1 chk("bp release", instr_ready, 1'b1);
        step("bp go");
        chk("bp next rd", rd_addr, 5'd11);
        instr_valid = 0; flush = 1;
        step("flush"); flush = 0;

        // Flush priority over accept and writeback
        instr = enc(LUI, 3, 0, 0); instr_valid = 1;
        step("lui x3");
        instr = enc(LUI, 4, 0, 0); flush = 1; wb_valid = 1; wb_addr = 3;
        #1 chk("flush instr_ready", instr_ready, 1'b0);
        step("flush all");
        flush = 0; wb_valid = 0;
        chk("flush issue_valid", issue_valid, 1'b0);
        chk("flush keeps rd", rd_addr, 5'd3);
        chk("flush no err", sb_err, 1'b0);
        instr = enc(OP, 8, 3, 0);
        #1 chk("flush cleared x3", hazard, 1'b0);
        step("add x8");
        chk("add x8 rd", rd_addr, 5'd8);

        // NREG=16 instance: out-of-range source, sticky sb_err
        instr_valid = 0; rst = 1;
        step("rst16"); step("rst16");
        rst = 0;
        instr = enc(OP, 1, 20, 2); instr_valid = 1;
        #1 chk("n16 hazard", e_hazard, 1'b0);
        chk("n16 ready", e_instr_ready, 1'b1);
        step("n16 add");
        instr_valid = 0;
        chk("n16 ill_reg", e_ill_reg, 1'b1);
        chk("n16 issue_valid", e_issue_valid, 1'b1);
        chk("n16 rs1_addr", e_rs1_addr, 5'd20);
        wb_valid = 1; wb_addr = 9;
        step("n16 wb x9");
        wb_valid = 0;
        chk("n16 sb_err set", e_sb_err, 1'b1);
        step("n16 idle"); step("n16 idle");
        chk("n16 sb_err sticky", e_sb_err, 1'b1);
        rst = 1;
        step("n16 rst");
        rst = 0;
        chk("n16 sb_err cleared", e_sb_err, 1'b0);
        chk("n16 ill cleared", e_ill_reg, 1'b0);

        // Randomized traffic against the model
        rst = 1; step("rnd rst"); rst = 0;
        for (int c = 0; c < 800; c++) begin
            int unsigned pl [$];
            rst         = ($urandom_range(0, 199) == 0);
            flush       = ($urandom_range(0, 39) == 0);
            instr_valid = ($urandom_range(0, 3) != 0);
            issue_ready = ($urandom_range(0, 9) < 7);
            instr = $urandom;
            instr[6:0]   = ops[$urandom_range(0, 11)];
            instr[11:7]  = 5'($urandom_range(0, 7));
            instr[19:15] = 5'($urandom_range(0, 7));
            instr[24:20] = 5'($urandom_range(0, 7));
            for (int unsigned r = 1; r < 8; r++) if (m_cnt[r] != 0) pl.push_back(r);
            wb_valid = ($urandom_range(0, 2) == 0);
            if (pl.size() != 0 && $urandom_range(0, 19) != 0)
                wb_addr = 5'(pl[$urandom_range(0, pl.size() - 1)]);
            else
                wb_addr = 5'($urandom_range(0, 7));
            step("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
